// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronises, debounces and edge-flags GPIO pins,
// and timestamps the latest accepted level change.
module gpio_input_conditioner #(
    parameter int N_CH       = 8,
    parameter int SAMPLE_DIV = 65536,
    parameter int DEBOUNCE   = 3,
    parameter int TS_W       = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [N_CH-1:0] din,
    input  logic [N_CH-1:0] clr,
    input  logic [N_CH-1:0] irq_mask,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise_evt,
    output logic [N_CH-1:0] fall_evt,
    output logic            irq,
    output logic [TS_W-1:0] timestamp,
    output logic [TS_W-1:0] last_ts,
    output logic            tick
);
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

    logic [N_CH-1:0]         s1_q, s2_q, dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [TS_W-1:0]         ts_q, ts_d, last_q, last_d;
    logic                    irq_q, irq_d;

    assign tick = pre_q == PMAX;

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        ts_d  = ts_q + 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            // a sample matching the stable level restarts the filter
            cnt_d[i]  = !tick ? cnt_q[i] :
                        (s2_q[i] == dout_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
            dout_d[i] = tick && s2_q[i] != dout_q[i] && cnt_q[i] == CMAX ? s2_q[i] : dout_q[i];
        end
        rise_d = (rise_q & ~clr) | (dout_d & ~dout_q);
        fall_d = (fall_q & ~clr) | (~dout_d & dout_q);
        irq_d  = |((rise_q | fall_q) & ~irq_mask);
        last_d = dout_d != dout_q ? ts_d : last_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
            pre_q  <= '0;
            ts_q   <= '0;
            last_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            ts_q   <= ts_d;
            last_q <= last_d;
            irq_q  <= irq_d;
        end
    end

    assign dout      = dout_q;
    assign rise_evt  = rise_q;
    assign fall_evt  = fall_q;
    assign irq       = irq_q;
    assign timestamp = ts_q;
    assign last_ts   = last_q;
endmodule
